// File: rtl/ll_event_detector_if.sv
// Bus bundle between the line-length feature source / host and ll_event_detector.
// en is a valid-only strobe: there is no ready, so every cycle with en=1 is consumed.
interface ll_event_detector_if #(
   parameter int data_width = 31,
   parameter int cnt_width  = 16
);
   logic signed [data_width:0] din;
   logic                       en;
   logic signed [data_width:0] thr_hi;
   logic signed [data_width:0] thr_lo;
   logic                       alarm;
   logic                       onset;
   logic                       offset;
   logic [cnt_width-1:0]       event_cnt;
   logic [7:0]                 run_cnt;
   logic [1:0]                 state_dbg;

   modport master (
      output din, en, thr_hi, thr_lo,
      input  alarm, onset, offset, event_cnt, run_cnt, state_dbg
   );

   modport slave (
      input  din, en, thr_hi, thr_lo,
      output alarm, onset, offset, event_cnt, run_cnt, state_dbg
   );
endinterface

// File: rtl/ll_event_detector.sv
// Debounced, hysteretic threshold alarm on the line-length feature stream, with
// registered onset/offset pulses and a saturating onset counter.
module ll_event_detector #(
   parameter int data_width = 31,
   parameter int onset_len  = 4,
   parameter int offset_len = 8,
   parameter int cnt_width  = 16
) (
   input logic               clk,
   input logic               rst,
   ll_event_detector_if.slave bus
);
   typedef enum logic [1:0] {
      QUIET   = 2'd0,
      ARM     = 2'd1,
      ALARM   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic [7:0] ONSET_LEN  = 8'(onset_len);
   localparam logic [7:0] OFFSET_LEN = 8'(offset_len);

   state_t               state_q, state_d;
   logic [7:0]           run_q, run_d;
   logic [cnt_width-1:0] cnt_q, cnt_d;
   logic                 onset_q, onset_d;
   logic                 offset_q, offset_d;

   logic signed [data_width:0] din_s, thr_hi_s, thr_lo_s;
   logic                       hi, lo;
   logic [7:0]                 run_inc;

   assign din_s    = bus.din;
   assign thr_hi_s = bus.thr_hi;
   assign thr_lo_s = bus.thr_lo;
   assign hi       = din_s > thr_hi_s;
   assign lo       = din_s < thr_lo_s;
   assign run_inc  = run_q + 8'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= QUIET;
         run_q    <= 8'd0;
         cnt_q    <= '0;
         onset_q  <= 1'b0;
         offset_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         cnt_q    <= cnt_d;
         onset_q  <= onset_d;
         offset_q <= offset_d;
      end
   end

   // run_q is always 0 in QUIET and ALARM, so run_inc starts every run at 1.
   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      cnt_d    = cnt_q;
      onset_d  = 1'b0;
      offset_d = 1'b0;
      if (bus.en) begin
         case (state_q)
            QUIET, ARM: begin
               if (hi) begin
                  if (run_inc == ONSET_LEN) begin
                     state_d = ALARM;
                     run_d   = 8'd0;
                     onset_d = 1'b1;
                     cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + cnt_width'(1);
                  end else begin
                     state_d = ARM;
                     run_d   = run_inc;
                  end
               end else begin
                  state_d = QUIET;
                  run_d   = 8'd0;
               end
            end
            ALARM, RELEASE: begin
               if (lo) begin
                  if (run_inc == OFFSET_LEN) begin
                     state_d  = QUIET;
                     run_d    = 8'd0;
                     offset_d = 1'b1;
                  end else begin
                     state_d = RELEASE;
                     run_d   = run_inc;
                  end
               end else begin
                  state_d = ALARM;
                  run_d   = 8'd0;
               end
            end
            default: begin
               state_d = QUIET;
               run_d   = 8'd0;
            end
         endcase
      end
   end

   assign bus.alarm     = (state_q == ALARM) || (state_q == RELEASE);
   assign bus.onset     = onset_q;
   assign bus.offset    = offset_q;
   assign bus.event_cnt = cnt_q;
   assign bus.run_cnt   = run_q;
   assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_ll_event_detector.sv
// Directed bench for ll_event_detector: a two-mode streak model feeds an expected
// queue checked every cycle, plus hand-computed literal checks per scenario.
module tb_ll_event_detector;
   localparam int DW     = 31;
   localparam int ONSET  = 4;
   localparam int OFFSET = 8;
   localparam int CW     = 4;
   localparam int W      = 3 + CW + 8;
   localparam int CMAX   = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ll_event_detector_if #(.data_width(DW), .cnt_width(CW)) bus ();

   ll_event_detector #(
      .data_width(DW),
      .onset_len (ONSET),
      .offset_len(OFFSET),
      .cnt_width (CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [W-1:0] exp_q[$];

   task automatic cmp(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Model: one alarm flag and one streak of samples meeting the compare relevant to it.
   bit m_alarm;
   int m_streak, m_events;
   bit m_on, m_off;
   initial begin
      forever begin
         @(posedge clk);
         m_on  = 1'b0;
         m_off = 1'b0;
         if (rst) begin
            m_alarm  = 1'b0;
            m_streak = 0;
            m_events = 0;
         end else if (bus.en) begin
            bit q;
            if (m_alarm) q = longint'(bus.din) < longint'(bus.thr_lo);
            else         q = longint'(bus.din) > longint'(bus.thr_hi);
            if (q) begin
               m_streak++;
               if (m_streak == (m_alarm ? OFFSET : ONSET)) begin
                  m_alarm  = !m_alarm;
                  m_streak = 0;
                  if (m_alarm) begin
                     m_on = 1'b1;
                     if (m_events < CMAX) m_events++;
                  end else begin
                     m_off = 1'b1;
                  end
               end
            end else begin
               m_streak = 0;
            end
         end
         exp_q.push_back({m_alarm, m_on, m_off, CW'(m_events), 8'(m_streak)});
      end
   end

   initial begin
      forever begin
         logic [W-1:0] e;
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            cmp("exp_q_empty", 0, 1);
         end else begin
            e = exp_q.pop_front();
            cmp("alarm",     int'(bus.alarm),     int'(e[W-1]));
            cmp("onset",     int'(bus.onset),     int'(e[W-2]));
            cmp("offset",    int'(bus.offset),    int'(e[W-3]));
            cmp("event_cnt", int'(bus.event_cnt), int'(e[8 +: CW]));
            cmp("run_cnt",   int'(bus.run_cnt),   int'(e[7:0]));
         end
      end
   end

   task automatic step(input logic signed [DW:0] d, input logic e);
      @(negedge clk);
      bus.din = d;
      bus.en  = e;
      @(posedge clk);
      #2;
   endtask

   task automatic set_thr(input logic signed [DW:0] h, input logic signed [DW:0] l);
      bus.thr_hi = h;
      bus.thr_lo = l;
   endtask

   logic signed [DW:0] most_neg;
   logic signed [DW:0] most_pos;
   int en_pat [7]  = '{1, 0, 0, 1, 0, 1, 1};
   int run_pat[7]  = '{1, 1, 1, 2, 2, 3, 0};
   int s2_din [5]  = '{1500, 1500, 1500, 1000, 1500};
   int s2_run [5]  = '{1, 2, 3, 0, 1};

   initial begin
      most_neg = 32'sh8000_0000;
      most_pos = 32'sh7FFF_FFFF;
      bus.din = '0;
      bus.en  = 1'b0;
      set_thr(0, 0);
      @(posedge clk);
      #2;
      cmp("rst_alarm", int'(bus.alarm), 0);
      cmp("rst_onset", int'(bus.onset), 0);
      cmp("rst_offset", int'(bus.offset), 0);
      cmp("rst_event_cnt", int'(bus.event_cnt), 0);
      cmp("rst_run_cnt", int'(bus.run_cnt), 0);
      @(negedge clk);
      rst = 1'b0;

      // Scenario 1: four highs give onset after the 4th sample.
      set_thr(1000, 300);
      for (int i = 0; i < 4; i++) begin
         step(1500, 1'b1);
         cmp("s1_onset", int'(bus.onset), (i == 3) ? 1 : 0);
      end
      cmp("s1_alarm", int'(bus.alarm), 1);
      cmp("s1_event_cnt", int'(bus.event_cnt), 1);
      step(500, 1'b1);
      cmp("s1_onset_clear", int'(bus.onset), 0);

      // Scenario 3: broken release run, then a full one.
      for (int i = 0; i < 7; i++) begin
         step(100, 1'b1);
         cmp("s3_run", int'(bus.run_cnt), i + 1);
         cmp("s3_offset", int'(bus.offset), 0);
      end
      step(500, 1'b1);
      cmp("s3_run_break", int'(bus.run_cnt), 0);
      cmp("s3_alarm_held", int'(bus.alarm), 1);
      for (int i = 0; i < 8; i++) begin
         step(100, 1'b1);
         cmp("s3_offset2", int'(bus.offset), (i == 7) ? 1 : 0);
      end
      cmp("s3_alarm_low", int'(bus.alarm), 0);
      step(500, 1'b1);
      cmp("s3_offset_clear", int'(bus.offset), 0);

      // Scenario 2: a sample equal to thr_hi breaks the onset run.
      for (int i = 0; i < 5; i++) begin
         step(s2_din[i], 1'b1);
         cmp("s2_run", int'(bus.run_cnt), s2_run[i]);
         cmp("s2_alarm", int'(bus.alarm), 0);
      end
      step(0, 1'b1);
      cmp("s2_run_end", int'(bus.run_cnt), 0);

      // Scenario 5: en gaps with junk on din do not break or advance the run.
      for (int i = 0; i < 7; i++) begin
         if (en_pat[i] == 1) step(1500, 1'b1);
         else                step($urandom, 1'b0);
         cmp("s5_run", int'(bus.run_cnt), run_pat[i]);
         cmp("s5_onset", int'(bus.onset), (i == 6) ? 1 : 0);
      end
      cmp("s5_event_cnt", int'(bus.event_cnt), 2);
      for (int i = 0; i < 8; i++) step(100, 1'b1);
      cmp("s5_alarm_low", int'(bus.alarm), 0);

      // Scenario 4: signed extremes.
      set_thr(-2222, -3000);
      for (int i = 0; i < 4; i++) step(-1111, 1'b1);
      cmp("s4_onset", int'(bus.onset), 1);
      cmp("s4_event_cnt", int'(bus.event_cnt), 3);
      for (int i = 0; i < 8; i++) step(most_neg, 1'b1);
      cmp("s4_offset", int'(bus.offset), 1);
      set_thr(most_pos, -3000);
      for (int i = 0; i < 3; i++) begin
         step(most_pos, 1'b1);
         cmp("s4_never_hi", int'(bus.run_cnt), 0);
      end
      set_thr(most_neg, -3000);
      step(most_pos, 1'b1);
      cmp("s4_pos_gt_neg", int'(bus.run_cnt), 1);
      step(most_neg, 1'b1);
      cmp("s4_neg_eq_neg", int'(bus.run_cnt), 0);

      // Inverted thresholds: one sample satisfies both compares.
      set_thr(100, 500);
      for (int i = 0; i < 4; i++) step(300, 1'b1);
      cmp("inv_onset", int'(bus.onset), 1);
      for (int i = 0; i < 8; i++) step(300, 1'b1);
      cmp("inv_offset", int'(bus.offset), 1);

      // Saturation: event_cnt sticks at all-ones while onset keeps pulsing.
      set_thr(1000, 300);
      for (int k = 0; k < 12; k++) begin
         for (int i = 0; i < 4; i++) step(1500, 1'b1);
         cmp("sat_onset", int'(bus.onset), 1);
         for (int i = 0; i < 8; i++) step(100, 1'b1);
      end
      cmp("sat_event_cnt", int'(bus.event_cnt), CMAX);

      // Scenario 6: async reset mid-release.
      for (int i = 0; i < 4; i++) step(1500, 1'b1);
      for (int i = 0; i < 5; i++) step(100, 1'b1);
      cmp("s6_run5", int'(bus.run_cnt), 5);
      #2;
      rst = 1'b1;
      #1;
      cmp("s6_rst_alarm", int'(bus.alarm), 0);
      cmp("s6_rst_onset", int'(bus.onset), 0);
      cmp("s6_rst_offset", int'(bus.offset), 0);
      cmp("s6_rst_event_cnt", int'(bus.event_cnt), 0);
      cmp("s6_rst_run_cnt", int'(bus.run_cnt), 0);
      @(negedge clk);
      bus.en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1500, 1'b1);
         cmp("s6_run", int'(bus.run_cnt), i + 1);
         cmp("s6_onset", int'(bus.onset), 0);
         cmp("s6_alarm", int'(bus.alarm), 0);
      end
      step(0, 1'b1);
      cmp("s6_run_end", int'(bus.run_cnt), 0);
      step(0, 1'b0);
      step(0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
